// File: rtl/traffic_light_ctrl.sv
// Two-approach intersection controller: A/B green-yellow-allred cycle,
// pedestrian green cut, flashing-yellow night mode, binary and BCD
// countdown. A single clock domain with an internal tick enable.
module traffic_light_ctrl #(
  parameter int unsigned F_CLK     = 50000000,
  parameter int unsigned TICK_HZ   = 1,
  parameter int unsigned T_GREEN_A = 30,
  parameter int unsigned T_GREEN_B = 20,
  parameter int unsigned T_YELLOW  = 5,
  parameter int unsigned T_ALLRED  = 2,
  parameter int unsigned T_PED_CUT = 5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ped_req,
  input  logic       night_mode,
  output logic [2:0] led_a,
  output logic [2:0] led_b,
  output logic [2:0] phase,
  output logic [6:0] remain,
  output logic [3:0] bcd_tens,
  output logic [3:0] bcd_ones,
  output logic       tick,
  output logic       ped_ack
);

  localparam int unsigned DIV = F_CLK / TICK_HZ;
  localparam int unsigned DW  = $clog2(DIV);

  // Active-low lamp codes: [0] red, [1] yellow, [2] green
  localparam logic [2:0] LAMP_RED = 3'b110;
  localparam logic [2:0] LAMP_YEL = 3'b101;
  localparam logic [2:0] LAMP_GRN = 3'b011;
  localparam logic [2:0] LAMP_OFF = 3'b111;

  typedef enum logic [2:0] {
    A_GREEN  = 3'd0,
    A_YELLOW = 3'd1,
    AR1      = 3'd2,
    B_GREEN  = 3'd3,
    B_YELLOW = 3'd4,
    AR2      = 3'd5,
    NIGHT    = 3'd6
  } phase_t;

  logic [DW-1:0] div_cnt;
  phase_t        state, nxt_state;
  logic [6:0]    rem, nxt_rem;
  logic          ped_pending, nxt_pending;
  logic          nxt_ack;
  logic          yel_on, nxt_yel;
  logic [2:0]    nxt_led_a, nxt_led_b;
  logic          is_green, cut;

  function automatic phase_t next_phase(input phase_t p);
    case (p)
      A_GREEN:  next_phase = A_YELLOW;
      A_YELLOW: next_phase = AR1;
      AR1:      next_phase = B_GREEN;
      B_GREEN:  next_phase = B_YELLOW;
      B_YELLOW: next_phase = AR2;
      default:  next_phase = A_GREEN;
    endcase
  endfunction

  function automatic logic [6:0] duration(input phase_t p);
    case (p)
      A_GREEN:            duration = 7'(T_GREEN_A);
      B_GREEN:            duration = 7'(T_GREEN_B);
      A_YELLOW, B_YELLOW: duration = 7'(T_YELLOW);
      AR1, AR2:           duration = 7'(T_ALLRED);
      default:            duration = '0;
    endcase
  endfunction

  assign tick = (div_cnt == DW'(DIV - 1));

  // Free-running tick divider, 0..DIV-1
  always_ff @(posedge clk) begin
    if (!rst_n)    div_cnt <= '0;
    else if (tick) div_cnt <= '0;
    else           div_cnt <= div_cnt + 1'b1;
  end

  // Next phase/countdown/pedestrian state; night beats cut, cut beats tick
  always_comb begin
    nxt_state   = state;
    nxt_rem     = rem;
    nxt_pending = ped_pending;
    nxt_ack     = 1'b0;
    nxt_yel     = yel_on;
    is_green    = (state == A_GREEN) || (state == B_GREEN);
    cut         = is_green && ped_pending && (rem > 7'(T_PED_CUT));

    if (tick && night_mode && (state != NIGHT)) begin
      nxt_state = NIGHT;
      nxt_rem   = '0;
      nxt_yel   = 1'b1;
    end else if (tick && (state == NIGHT)) begin
      if (!night_mode) begin
        nxt_state = AR2;
        nxt_rem   = 7'(T_ALLRED);
      end else begin
        nxt_yel = ~yel_on;
      end
    end else if (cut) begin
      nxt_rem     = 7'(T_PED_CUT);
      nxt_ack     = 1'b1;
      nxt_pending = 1'b0;
    end else if (tick) begin
      if (rem == 7'd1) begin
        nxt_state = next_phase(state);
        nxt_rem   = duration(next_phase(state));
      end else begin
        nxt_rem = rem - 7'd1;
      end
    end

    if (ped_req && (state != NIGHT)) nxt_pending = 1'b1;

    // Entering a yellow or night drops any request, including one this cycle
    if ((nxt_state != state) &&
        ((nxt_state == A_YELLOW) || (nxt_state == B_YELLOW) || (nxt_state == NIGHT)))
      nxt_pending = 1'b0;
  end

  // Lamp codes decoded from the next state so they move with phase
  always_comb begin
    nxt_led_a = LAMP_RED;
    nxt_led_b = LAMP_RED;
    case (nxt_state)
      A_GREEN:  nxt_led_a = LAMP_GRN;
      A_YELLOW: nxt_led_a = LAMP_YEL;
      B_GREEN:  nxt_led_b = LAMP_GRN;
      B_YELLOW: nxt_led_b = LAMP_YEL;
      NIGHT: begin
        nxt_led_a = nxt_yel ? LAMP_YEL : LAMP_OFF;
        nxt_led_b = nxt_yel ? LAMP_YEL : LAMP_OFF;
      end
      default: ;
    endcase
  end

  // Controller state and registered outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= A_GREEN;
      rem         <= 7'(T_GREEN_A);
      ped_pending <= 1'b0;
      ped_ack     <= 1'b0;
      yel_on      <= 1'b0;
      led_a       <= LAMP_GRN;
      led_b       <= LAMP_RED;
    end else begin
      state       <= nxt_state;
      rem         <= nxt_rem;
      ped_pending <= nxt_pending;
      ped_ack     <= nxt_ack;
      yel_on      <= nxt_yel;
      led_a       <= nxt_led_a;
      led_b       <= nxt_led_b;
    end
  end

  assign phase  = state;
  assign remain = rem;

  // BCD split of the countdown for the display path
  always_comb begin
    bcd_tens = 4'(rem / 7'd10);
    bcd_ones = 4'(rem % 7'd10);
  end

endmodule

// File: tb/tb_traffic_light_ctrl.sv
// Scoreboard bench for traffic_light_ctrl (DIV=10). Expected output
// snapshots are queued with hand-computed cycle stamps; a monitor pops one
// each time the DUT's visible outputs change or reset is released.
module tb_traffic_light_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ped_req = 1'b0;
  logic       night_mode = 1'b0;
  logic [2:0] led_a, led_b, phase;
  logic [6:0] remain;
  logic [3:0] bcd_tens, bcd_ones;
  logic       tick, ped_ack;

  always #5 clk = ~clk;

  traffic_light_ctrl #(
    .F_CLK(10), .TICK_HZ(1), .T_GREEN_A(30), .T_GREEN_B(20),
    .T_YELLOW(5), .T_ALLRED(2), .T_PED_CUT(5)
  ) dut (
    .clk(clk), .rst_n(rst_n), .ped_req(ped_req), .night_mode(night_mode),
    .led_a(led_a), .led_b(led_b), .phase(phase), .remain(remain),
    .bcd_tens(bcd_tens), .bcd_ones(bcd_ones), .tick(tick), .ped_ack(ped_ack)
  );

  typedef struct {
    int unsigned cyc;
    logic [2:0]  ph;
    logic [6:0]  rem;
    logic [2:0]  la;
    logic [2:0]  lb;
    logic        ack;
  } exp_t;

  exp_t        q[$];
  int unsigned total = 0;
  int unsigned bad = 0;
  int unsigned cyc = 0;
  logic        rst_at_edge = 1'b1;
  logic        armed = 1'b0;

  // Cycles since the last clock edge that saw reset asserted
  always @(posedge clk) begin
    rst_at_edge <= rst_n;
    armed       <= 1'b1;
    cyc         <= rst_n ? cyc + 1 : 0;
  end

  function automatic logic [5:0] lamps(input logic [2:0] ph);
    case (ph)
      3'd0:    lamps = {3'b011, 3'b110};
      3'd1:    lamps = {3'b101, 3'b110};
      3'd3:    lamps = {3'b110, 3'b011};
      3'd4:    lamps = {3'b110, 3'b101};
      default: lamps = {3'b110, 3'b110};
    endcase
  endfunction

  task automatic push(input int unsigned c, input logic [2:0] ph, input logic [6:0] r,
                      input logic [2:0] la, input logic [2:0] lb, input logic ack);
    exp_t e;
    e.cyc = c; e.ph = ph; e.rem = r; e.la = la; e.lb = lb; e.ack = ack;
    q.push_back(e);
  endtask

  // One snapshot per tick while remain counts hi down to lo
  task automatic run(input logic [2:0] ph, input int hi, input int lo, input int unsigned start);
    logic [5:0] l;
    l = lamps(ph);
    for (int k = 0; hi - k >= lo; k++)
      push(start + 10 * k, ph, 7'(hi - k), l[5:3], l[2:0], 1'b0);
  endtask

  logic [2:0] p_ph, p_la, p_lb;
  logic [6:0] p_rem;
  logic       p_ack;
  logic       changed, fire;
  exp_t       e_m;

  // Monitor: tick cadence every cycle, snapshot compare on each output change
  always @(negedge clk) begin
    if (armed) begin
      total = total + 1;
      if (tick !== ((cyc % 10) == 9)) begin
        bad = bad + 1;
        $display("FAIL tick cyc=%0d got=%b need=%b", cyc, tick, (cyc % 10) == 9);
      end
      changed = (phase !== p_ph) || (remain !== p_rem) || (led_a !== p_la) ||
                (led_b !== p_lb) || (ped_ack !== p_ack);
      fire = (!rst_at_edge && rst_n) || (rst_at_edge && changed);
      if (fire) begin
        total = total + 1;
        if (q.size() == 0) begin
          bad = bad + 1;
          $display("FAIL unexpected cyc=%0d got ph=%0d rem=%0d a=%b b=%b ack=%b need none",
                   cyc, phase, remain, led_a, led_b, ped_ack);
        end else begin
          e_m = q.pop_front();
          if (cyc != e_m.cyc || phase !== e_m.ph || remain !== e_m.rem ||
              led_a !== e_m.la || led_b !== e_m.lb || ped_ack !== e_m.ack ||
              bcd_tens !== 4'(e_m.rem / 10) || bcd_ones !== 4'(e_m.rem % 10)) begin
            bad = bad + 1;
            $display("FAIL evt got cyc=%0d ph=%0d rem=%0d bcd=%0d/%0d a=%b b=%b ack=%b need cyc=%0d ph=%0d rem=%0d bcd=%0d/%0d a=%b b=%b ack=%b",
                     cyc, phase, remain, bcd_tens, bcd_ones, led_a, led_b, ped_ack,
                     e_m.cyc, e_m.ph, e_m.rem, e_m.rem / 10, e_m.rem % 10,
                     e_m.la, e_m.lb, e_m.ack);
          end
        end
      end
      p_ph = phase; p_rem = remain; p_la = led_a; p_lb = led_b; p_ack = ped_ack;
    end
  end

  task automatic at_cyc(input int unsigned n);
    int unsigned g;
    g = 0;
    do begin
      @(posedge clk); #1;
      g++;
    end while (cyc != n && g < 5000);
    if (cyc != n) begin
      total = total + 1;
      bad = bad + 1;
      $display("FAIL wait got cyc=%0d need %0d", cyc, n);
    end
  endtask

  task automatic pulse_ped();
    ped_req = 1'b1;
    @(posedge clk); #1;
    ped_req = 1'b0;
  endtask

  initial begin
    // Full undisturbed cycle after reset (first record is the reset state)
    run(0, 30, 1, 0);     run(1, 5, 1, 300);  run(2, 2, 1, 350);
    run(3, 20, 1, 370);   run(4, 5, 1, 570);  run(5, 2, 1, 620);
    // Cut at remain=18
    run(0, 30, 18, 640);
    push(764, 0, 5, 3'b011, 3'b110, 1'b1);
    push(765, 0, 5, 3'b011, 3'b110, 1'b0);
    run(0, 4, 1, 770);    run(1, 5, 1, 810);  run(2, 2, 1, 860);
    // Late request at remain=3: no cut, dropped at yellow
    run(3, 20, 1, 880);   run(4, 5, 1, 1080); run(5, 2, 1, 1130);
    // Cut coinciding with the tick at remain=12
    run(0, 30, 12, 1150);
    push(1340, 0, 5, 3'b011, 3'b110, 1'b1);
    push(1341, 0, 5, 3'b011, 3'b110, 1'b0);
    run(0, 4, 1, 1350);   run(1, 5, 1, 1390); run(2, 2, 1, 1440);
    // Night entry at B_GREEN remain=14, flashing, exit to AR2
    run(3, 20, 14, 1460);
    push(1530, 6, 0, 3'b101, 3'b101, 1'b0);
    push(1540, 6, 0, 3'b111, 3'b111, 1'b0);
    push(1550, 6, 0, 3'b101, 3'b101, 1'b0);
    push(1560, 6, 0, 3'b111, 3'b111, 1'b0);
    run(5, 2, 1, 1570);   run(0, 30, 1, 1590); run(1, 5, 1, 1890);
    run(2, 2, 1, 1940);   run(3, 20, 1, 1960); run(4, 5, 4, 2160);
    // Reset mid-B_YELLOW with a request pending
    run(0, 30, 25, 0);

    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    at_cyc(762);  pulse_ped();
    at_cyc(1052); pulse_ped();
    at_cyc(1338); pulse_ped();
    at_cyc(1522); night_mode = 1'b1;
    at_cyc(1542); pulse_ped();
    at_cyc(1562); night_mode = 1'b0;
    at_cyc(2172); pulse_ped();
    at_cyc(2175); rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    at_cyc(60);

    for (int i = 0; i < 50 && q.size() != 0; i++) @(posedge clk);
    total = total + 1;
    if (q.size() != 0) begin
      bad = bad + 1;
      $display("FAIL drain got %0d pending events need 0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
